// File: rtl/reg5_write_arbiter_pkg.sv
// Shared types and constants for the Register5biten write arbiter.
package reg_arb_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        VERIFY = 2'd2
    } arb_state_t;

    localparam int REG_WIDTH = 5;
endpackage

// File: rtl/reg5_write_arbiter_if.sv
// Requester-side handshake and register-side bus of the write arbiter.
interface reg5_write_arbiter_if
    import reg_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = REG_WIDTH
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] wdata;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       ack;
    logic                   err;
    logic                   busy;
    logic                   reg_write_en;
    logic [WIDTH-1:0]       reg_data_in;
    logic [WIDTH-1:0]       reg_data_out;

    modport master (
        output req, wdata, reg_data_out,
        input  gnt, ack, err, busy, reg_write_en, reg_data_in
    );

    modport slave (
        input  req, wdata, reg_data_out,
        output gnt, ack, err, busy, reg_write_en, reg_data_in
    );
endinterface

// File: rtl/reg5_write_arbiter_rr_pick.sv
// Combinational round-robin selector: first set req bit at or after ptr, wrapping.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] win_idx,
    output logic             valid
);
    int idx;

    always_comb begin
        valid   = 1'b0;
        win_idx = '0;
        idx     = 0;
        for (int off = 0; off < N_REQ; off++) begin
            idx = (int'(ptr) + off) % N_REQ;
            if (!valid && req[IDX_W'(idx)]) begin
                valid   = 1'b1;
                win_idx = IDX_W'(idx);
            end
        end
    end
endmodule

// File: rtl/reg5_write_arbiter.sv
// Round-robin write arbiter: one grant at a time, single write_en pulse, read-back verify.
module reg5_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = REG_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    reg5_write_arbiter_if.slave  bus
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] win_q, win_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;

    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;
    logic [WIDTH-1:0] wdata_arr [N_REQ];

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
        return {{(N_REQ-1){1'b0}}, 1'b1} << i;
    endfunction

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign wdata_arr[g] = bus.wdata[g*WIDTH +: WIDTH];
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req     (bus.req),
        .ptr     (ptr_q),
        .win_idx (pick_idx),
        .valid   (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            data_q  <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            data_q  <= data_d;
            gnt_q   <= gnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        data_d  = data_q;
        gnt_d   = gnt_q;
        case (state_q)
            IDLE: begin
                // wdata is captured here only; later changes cannot affect the write
                if (pick_valid) begin
                    win_d   = pick_idx;
                    data_d  = wdata_arr[pick_idx];
                    gnt_d   = onehot(pick_idx);
                    state_d = WRITE;
                end
            end
            WRITE: begin
                ptr_d   = (win_q == IDX_W'(N_REQ-1)) ? '0 : win_q + 1'b1;
                state_d = VERIFY;
            end
            VERIFY: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.gnt          = gnt_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.reg_write_en = (state_q == WRITE);
    assign bus.reg_data_in  = (state_q == WRITE) ? data_q : '0;
    assign bus.ack          = (state_q == VERIFY) ? onehot(win_q) : '0;
    assign bus.err          = (state_q == VERIFY) && (bus.reg_data_out != data_q);
endmodule

// File: doc/reg5_write_arbiter.md
# reg5_write_arbiter

Round-robin write arbiter and sequencer for a shared `Register5biten` storage register. It accepts write requests from `N_REQ` requesters and grants one at a time. For each grant it drives exactly one `write_en` pulse into the register, then reads the value back and acknowledges the winner. It sits between the requesting control units and the register, and is the only block allowed to drive the register's `write_en`/`data_in`.

## Interface
Parameters:
- `N_REQ`, 4 — number of requesters; legal range 2..8.
- `WIDTH`, 5 — register data width; must match the attached register.

Ports:
- `clk` input 1 — single clock; all state updates on the rising edge.
- `rst` input 1 — synchronous, active-high reset.
- `req` input `N_REQ` — write request per requester; level-sensitive.
- `wdata` input `N_REQ*WIDTH` — write data; requester i occupies bits [i*WIDTH +: WIDTH].
- `gnt` output `N_REQ` — one-hot grant, registered.
- `ack` output `N_REQ` — one-cycle one-hot completion pulse to the granted requester.
- `err` output 1 — one-cycle pulse with `ack` when the read-back value differs from the written value.
- `busy` output 1 — high whenever the FSM is not in IDLE.
- `reg_write_en` output 1 — to the register's `write_en`.
- `reg_data_in` output `WIDTH` — to the register's `data_in`.
- `reg_data_out` input `WIDTH` — from the register's `data_out`.

Reset is synchronous and active-high on `clk`. It applies to `rst` only; there is no asynchronous path.

## Operation
- FSM states: IDLE, WRITE, VERIFY.
- **IDLE:**
  - If any `req` bit is high, select a winner by round-robin starting at `ptr`.
  - Latch `win_idx` and `data_q = wdata[win_idx]`.
  - Set `gnt[win_idx]` and go to WRITE.
  - Otherwise stay in IDLE.
- **WRITE:**
  - `reg_write_en = 1`, `reg_data_in = data_q`.
  - Set `ptr = (win_idx+1) mod N_REQ`, then go to VERIFY.
- **VERIFY:**
  - Compare `reg_data_out` with `data_q`.
  - Pulse `ack[win_idx]`; pulse `err` on mismatch.
  - Clear `gnt` and return to IDLE.
- `reg_data_in` is 0 whenever `reg_write_en` is 0.
- `wdata` is sampled only in the IDLE decision cycle. Later changes to `wdata` have no effect on the transaction.
- Requests arriving during WRITE or VERIFY wait. No request is lost while its `req` is held high.
- If a requester drops `req` after being granted, the transaction still completes and it still receives `ack`.
- A requester holding `req` high after `ack` competes again in the next IDLE cycle, after all others through round-robin.
- Round-robin order: search ptr, ptr+1, …, N_REQ-1, 0, …, ptr-1; the first set bit wins.
- Fairness bound: a continuously requesting requester is granted within `N_REQ` transactions.
- **Reset (including mid-operation):**
  - State goes to IDLE; `ptr` is set to 0; `data_q` and `win_idx` are set to 0.
  - All outputs go to 0.
  - An aborted transaction produces no `ack`.

## Timing
- Request seen high in IDLE at edge k:
  - `gnt` and `busy` are high from k+1.
  - `reg_write_en` is high during cycle k+1 to k+2; the register captures at edge k+2.
  - `ack`/`err` are high during cycle k+2 to k+3, while `gnt` is still high.
  - `gnt` and `busy` drop at k+3.
- One transaction takes 3 cycles including the IDLE decision cycle.
- Back-to-back throughput: one write every 3 cycles.
- Exactly one `reg_write_en` cycle per grant, and never two consecutive cycles high.
- `gnt` is one-hot or zero at all times. `ack` is one-hot or zero. `ack` is never asserted to a non-granted requester.

## Structure
- Shared package `reg_arb_pkg` contains:
  - the `arb_state_t` enum (IDLE, WRITE, VERIFY);
  - the `REG_WIDTH = 5` constant.
- One sub-module, `rr_pick`: combinational round-robin selector with inputs `req`, `ptr` and outputs `win_idx`, `valid`.
- The top level holds the FSM, `ptr`, `data_q`, and the output registers.

## Test plan
- **Single request:** after reset, `req = 4'b0100`, `wdata[2] = 5'b10110`.
  - Expect `gnt = 4'b0100` at k+1 and `reg_write_en` for one cycle with `reg_data_in = 10110`.
  - Expect `ack = 4'b0100` at k+2, `err = 0`, and the register then holds 10110.
- **All four requesting continuously, data i+1:** grants occur in order 0,1,2,3,0 every 3 cycles, and the register sequence is 1,2,3,4,1.
- **Request dropped and data changed after grant:** the requester drops `req` and changes `wdata` at k+1. The latched value is still written and `ack` is still pulsed.
- **`rst` asserted in the WRITE cycle:**
  - All outputs are 0 on the next cycle, no `ack` is issued, and the register resets to 0.
  - The next `req = 4'b1010` grants requester 1 first.
- **Forced mismatch:** the bench overrides `reg_data_out = 5'b00000` while `data_q = 5'b11111`. Expect `err` and `ack` to pulse together in VERIFY.
- **Invariant checker, run in all tests:** `gnt` and `ack` are one-hot-or-zero; `reg_write_en` is never high in two consecutive cycles.
